// File: rtl/aes192_stream_ctrl_pkg.sv
// Shared constants and helpers for the AES-192 stream controller.
package aes_ctrl_pkg;

    localparam int AES192_LAT = 13;
    localparam int BLK_W      = 128;
    localparam int KEY_W      = 192;
    localparam int INFL_W     = 5;
    localparam int CNT_W      = 32;

    function automatic int obuf_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/aes192_stream_ctrl_if.sv
// Stream, core and status signals of the AES-192 controller.
// Tag fields exist only when AES192_CTRL_TAG_EN is defined.
interface aes192_stream_ctrl_if #(
    parameter int TAG_W = 8
);
    import aes_ctrl_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [BLK_W-1:0]  in_data;
    logic [KEY_W-1:0]  in_key;
    logic              core_en;
    logic [BLK_W-1:0]  core_state;
    logic [KEY_W-1:0]  core_key;
    logic [BLK_W-1:0]  core_out;
    logic              out_valid;
    logic              out_ready;
    logic [BLK_W-1:0]  out_data;
    logic [INFL_W-1:0] inflight;
    logic [CNT_W-1:0]  blk_cnt;
`ifdef AES192_CTRL_TAG_EN
    logic [TAG_W-1:0]  in_tag;
    logic [TAG_W-1:0]  out_tag;
`endif

    modport master (
        output in_valid, in_data, in_key, core_out, out_ready,
`ifdef AES192_CTRL_TAG_EN
        output in_tag,
        input  out_tag,
`endif
        input  in_ready, core_en, core_state, core_key,
        input  out_valid, out_data, inflight, blk_cnt
    );

    modport slave (
        input  in_valid, in_data, in_key, core_out, out_ready,
`ifdef AES192_CTRL_TAG_EN
        input  in_tag,
        output out_tag,
`endif
        output in_ready, core_en, core_state, core_key,
        output out_valid, out_data, inflight, blk_cnt
    );

endinterface

// File: rtl/aes192_stream_ctrl_obuf.sv
// Small synchronous FIFO holding finished ciphertext (and tag).
module aes_ctrl_obuf
    import aes_ctrl_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int W     = 128
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic [W-1:0]                 data_i,
    output logic [W-1:0]                 data_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [obuf_cnt_w(DEPTH)-1:0] count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = obuf_cnt_w(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (do_push) wr_d = wr_q + AW'(1);
        if (do_pop)  rd_d = rd_q + AW'(1);
        unique case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage needs no reset; occupancy is tracked by cnt_q.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end

    assign data_o  = mem_q[rd_q];
    assign count_o = cnt_q;

endmodule

// File: rtl/aes192_stream_ctrl.sv
// Valid/ready stream wrapper around the 13-stage pipelined AES-192 core.
// Define AES192_CTRL_TAG_EN to carry a TAG_W sideband tag with each block.
module aes192_stream_ctrl
    import aes_ctrl_pkg::*;
#(
    parameter int LAT        = AES192_LAT,
    parameter int OBUF_DEPTH = 2,
    parameter int TAG_W      = 8
) (
    input  logic                clk,
    input  logic                rst,
    aes192_stream_ctrl_if.slave bus
);
`ifdef AES192_CTRL_TAG_EN
    localparam int FW = BLK_W + TAG_W;
`else
    localparam int FW = BLK_W;
`endif
    localparam int CW = obuf_cnt_w(OBUF_DEPTH);

    logic [LAT-1:0]   vld_q, vld_d;
    logic [CNT_W-1:0] blk_cnt_q, blk_cnt_d;
    logic             en, push, pop, full, empty;
    logic [CW-1:0]    cnt;
    logic [FW-1:0]    push_data, head;

    // Stall only when a finished block has nowhere to go; full is pre-pop.
    assign en   = !(vld_q[LAT-1] && full);
    assign push = en && vld_q[LAT-1];
    assign pop  = !empty && bus.out_ready;

    always_comb begin
        vld_d     = vld_q;
        blk_cnt_d = blk_cnt_q;
        if (en)  vld_d     = {vld_q[LAT-2:0], bus.in_valid};
        if (pop) blk_cnt_d = blk_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q     <= '0;
            blk_cnt_q <= '0;
        end else begin
            vld_q     <= vld_d;
            blk_cnt_q <= blk_cnt_d;
        end
    end

`ifdef AES192_CTRL_TAG_EN
    logic [TAG_W-1:0] tag_q [LAT];

    always_ff @(posedge clk) begin
        if (en) begin
            tag_q[0] <= bus.in_tag;
            for (int i = 1; i < LAT; i++) tag_q[i] <= tag_q[i-1];
        end
    end

    assign push_data    = {bus.core_out, tag_q[LAT-1]};
    assign bus.out_data = head[FW-1 -: BLK_W];
    assign bus.out_tag  = head[TAG_W-1:0];
`else
    assign push_data    = bus.core_out;
    assign bus.out_data = head;
`endif

    aes_ctrl_obuf #(
        .DEPTH (OBUF_DEPTH),
        .W     (FW)
    ) u_obuf (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (push_data),
        .data_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (cnt)
    );

    assign bus.in_ready   = en;
    assign bus.core_en    = en;
    assign bus.core_state = bus.in_data;
    assign bus.core_key   = bus.in_key;
    assign bus.out_valid  = !empty;
    assign bus.blk_cnt    = blk_cnt_q;
    assign bus.inflight   = INFL_W'($countones(vld_q)) + INFL_W'(cnt);

endmodule
